// File: rtl/bus_router.sv
// Single-host to N-target bus router: decodes an address tag, forwards one
// request at a time and returns the target response, a decode error or a timeout.
module bus_router #(
    parameter int                      AddrWidth     = 32,
    parameter int                      DataWidth     = 32,
    parameter int                      MaskWidth     = 4,
    parameter int                      TagWidth      = 2,
    parameter logic [2**TagWidth-1:0]  TargetMask    = '1,
    parameter bit                      StrictDecode  = 1'b0,
    parameter int                      TimeoutCycles = 0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               host_valid,
    output logic                               host_ready,
    input  logic                               host_we,
    input  logic [AddrWidth-1:0]               host_addr,
    input  logic [DataWidth-1:0]               host_wdata,
    input  logic [DataWidth/8-1:0]             host_be,
    output logic                               host_rsp_valid,
    output logic [DataWidth-1:0]               host_rdata,
    output logic                               host_err,
    output logic [2**TagWidth-1:0]             tgt_req,
    input  logic [2**TagWidth-1:0]             tgt_ready,
    output logic [AddrWidth-1:0]               tgt_addr,
    output logic                               tgt_we,
    output logic [DataWidth-1:0]               tgt_wdata,
    output logic [DataWidth/8-1:0]             tgt_be,
    input  logic [2**TagWidth-1:0]             tgt_rsp_valid,
    input  logic [(2**TagWidth)*DataWidth-1:0] tgt_rdata
);

    localparam int NumTargets  = 2**TagWidth;
    localparam int OffsetWidth = AddrWidth - MaskWidth;
    localparam int TimerWidth  = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [TimerWidth-1:0] TimerLast =
        TimerWidth'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                 state_reg, state_next;
    logic [TagWidth-1:0]    tag_reg, tag_next;
    logic [TimerWidth-1:0]  timer_reg, timer_next;
    logic                   rsp_valid_reg, rsp_valid_next;
    logic [DataWidth-1:0]   rdata_reg, rdata_next;
    logic                   err_reg, err_next;

    logic [TagWidth-1:0]    dec_tag;
    logic                   upper_zero;
    logic                   mapped;
    logic                   accept;
    logic                   rsp_hit;
    logic                   timed_out;
    logic [DataWidth-1:0]   rdata_slice [NumTargets];

    assign dec_tag = host_addr[OffsetWidth +: TagWidth];

    // Bits between the tag and the top of the address only exist when the tag is narrower than the mask.
    generate
        if (TagWidth < MaskWidth) begin : g_upper
            assign upper_zero = (host_addr[AddrWidth-1:OffsetWidth+TagWidth] == '0);
        end else begin : g_no_upper
            assign upper_zero = 1'b1;
        end
        if (TimeoutCycles > 0) begin : g_timeout
            assign timed_out = (timer_reg == TimerLast);
        end else begin : g_no_timeout
            assign timed_out = 1'b0;
        end
    endgenerate

    for (genvar gi = 0; gi < NumTargets; gi++) begin : g_slice
        assign rdata_slice[gi] = tgt_rdata[gi*DataWidth +: DataWidth];
    end

    assign mapped    = TargetMask[dec_tag] & (!StrictDecode | upper_zero);
    assign accept    = host_valid & host_ready;
    assign rsp_hit   = tgt_rsp_valid[tag_reg];

    assign tgt_addr  = {{MaskWidth{1'b0}}, host_addr[OffsetWidth-1:0]};
    assign tgt_we    = host_we;
    assign tgt_wdata = host_wdata;
    assign tgt_be    = host_be;

    assign host_rsp_valid = rsp_valid_reg;
    assign host_rdata     = rdata_reg;
    assign host_err       = err_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            tag_reg       <= '0;
            timer_reg     <= '0;
            rsp_valid_reg <= 1'b0;
            rdata_reg     <= '0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            tag_reg       <= tag_next;
            timer_reg     <= timer_next;
            rsp_valid_reg <= rsp_valid_next;
            rdata_reg     <= rdata_next;
            err_reg       <= err_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        tag_next       = tag_reg;
        timer_next     = timer_reg;
        rsp_valid_next = 1'b0;
        rdata_next     = rdata_reg;
        err_next       = err_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (mapped) begin
                        state_next = WAIT;
                        tag_next   = dec_tag;
                        timer_next = '0;
                    end else begin
                        rsp_valid_next = 1'b1;
                        err_next       = 1'b1;
                        rdata_next     = '0;
                    end
                end
            end
            WAIT: begin
                // A response in the expiry cycle wins over the timeout.
                if (rsp_hit) begin
                    state_next     = IDLE;
                    rsp_valid_next = 1'b1;
                    err_next       = 1'b0;
                    rdata_next     = rdata_slice[tag_reg];
                end else if (timed_out) begin
                    state_next     = IDLE;
                    rsp_valid_next = 1'b1;
                    err_next       = 1'b1;
                    rdata_next     = '0;
                end else begin
                    timer_next = timer_reg + TimerWidth'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        host_ready = 1'b0;
        tgt_req    = '0;
        if (state_reg == IDLE) begin
            if (mapped) begin
                tgt_req[dec_tag] = host_valid;
                host_ready       = tgt_ready[dec_tag];
            end else begin
                host_ready = 1'b1;
            end
        end
    end

endmodule

// File: doc/bus_router.md
Name: bus_router

Overview:
- Single-host to N-target bus router, one transaction outstanding at a time.
- Decodes a tag field in the host address to select a target, forwards the request with the tag and mask bits cleared, and routes that target's response back.
- Unmapped addresses and timed-out transactions return an error response.
- Sits between the CPU data port and the peripheral/memory targets; replaces the combinational address decoder as the bus fabric element.

Parameters:
- AddrWidth, 32, host/target address width.
- DataWidth, 32, read/write data width.
- MaskWidth, 4, number of top address bits cleared in the forwarded address. OffsetWidth = AddrWidth - MaskWidth.
- TagWidth, 2, tag field is addr[OffsetWidth+TagWidth-1:OffsetWidth]. Required: TagWidth <= MaskWidth. NumTargets = 2**TagWidth.
- TargetMask, all ones (NumTargets bits), bit i = 1 means tag i is mapped.
- StrictDecode, 0. When 1, any nonzero bit in addr[AddrWidth-1:OffsetWidth+TagWidth] makes the address unmapped.
- TimeoutCycles, 0, maximum cycles to wait for a target response. 0 disables the timeout.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- host_valid, input, 1, host request valid.
- host_ready, output, 1, request accepted when host_valid & host_ready.
- host_we, input, 1, write enable.
- host_addr, input, AddrWidth, request address.
- host_wdata, input, DataWidth, write data.
- host_be, input, DataWidth/8, byte enables.
- host_rsp_valid, output, 1, one-cycle response strobe.
- host_rdata, output, DataWidth, response data.
- host_err, output, 1, error flag, qualified by host_rsp_valid.
- tgt_req, output, NumTargets, one-hot request valid.
- tgt_ready, input, NumTargets, per-target request ready.
- tgt_addr, output, AddrWidth, masked address: {MaskWidth zeros, host_addr[OffsetWidth-1:0]}.
- tgt_we, output, 1, broadcast from host_we.
- tgt_wdata, output, DataWidth, broadcast from host_wdata.
- tgt_be, output, DataWidth/8, broadcast from host_be.
- tgt_rsp_valid, input, NumTargets, per-target response strobe.
- tgt_rdata, input, NumTargets*DataWidth, target i occupies bits [i*DataWidth +: DataWidth].

Behaviour:
- Reset values: state = IDLE, host_rsp_valid = 0, host_rdata = 0, host_err = 0, timer = 0, captured tag = 0.
- Reset mid-transaction abandons the transaction. No response is issued, and the late target response is ignored.
- Decode is combinational on host_addr. mapped = TargetMask[tag] & (!StrictDecode | upper bits == 0).
- IDLE, mapped address:
  - tgt_req[tag] = host_valid; all other tgt_req bits are 0.
  - host_ready = tgt_ready[tag].
  - On accept at cycle T: capture tag, clear timer, go to WAIT.
- IDLE, unmapped address:
  - host_ready = 1 and no tgt_req is asserted.
  - On accept at T: host_rsp_valid = 1, host_err = 1, host_rdata = 0 in cycle T+1. State stays IDLE.
- WAIT:
  - host_ready = 0 and tgt_req = 0.
  - Only tgt_rsp_valid[captured tag] is sampled. Strobes from other targets are ignored, as are all strobes in IDLE.
- Response sampled in cycle C (first possible C = T+1):
  - In C+1: host_rsp_valid = 1, host_rdata = registered tgt_rdata slice, host_err = 0.
  - State returns to IDLE in C+1, so a new request can be accepted in the same cycle host_rsp_valid is high.
- Writes also expect exactly one tgt_rsp_valid. For writes, host_rdata passes whatever the target drives.
- Timeout (TimeoutCycles > 0):
  - timer increments on each WAIT cycle without a response.
  - If no response is sampled in T+1..T+TimeoutCycles: host_rsp_valid = 1, host_err = 1, host_rdata = 0 in T+TimeoutCycles+1, and state returns to IDLE.
  - A response arriving in the same cycle the timer expires takes priority over the timeout.
  - Timer width = $clog2(TimeoutCycles+1).
- host_rsp_valid is high for exactly one cycle per accepted request. host_rdata and host_err hold their values until the next response.
- Host request signals must stay stable while host_valid & !host_ready (standard valid/ready).

Test Plan:
- Basic read routing. Config: MaskWidth=4, TagWidth=2, TargetMask=4'b0111.
  - Stimulus: read 0x1000_0040; target 1 ready; target 1 returns 0xDEADBEEF two cycles after accept.
  - Required: tgt_req = 4'b0010, tgt_addr = 0x0000_0040. host_rsp_valid for one cycle, 1 cycle after tgt_rsp_valid, with rdata 0xDEADBEEF and err 0.
- Unmapped tag.
  - Stimulus: read 0x3000_0000.
  - Required: host_ready = 1, tgt_req = 0, next cycle rsp_valid = 1, err = 1, rdata = 0.
- Strict decode.
  - Stimulus: read 0x5000_0000.
  - Required with StrictDecode=1: error response. With StrictDecode=0: target 1 request with tgt_addr = 0x0000_0000.
- Backpressure and stray responses.
  - Stimulus: tgt_ready[1] low for 3 cycles; while in WAIT on target 1, target 2 pulses tgt_rsp_valid.
  - Required: tgt_req[1] held for the 3 cycles, host_ready low. The stray target 2 strobe causes no host response; only target 1's data is returned.
- Timeout and back-to-back. Config: TimeoutCycles=8.
  - Stimulus: target never responds; target then responds late at T+12; a second request is held waiting.
  - Required: err response at T+9. The late response at T+12 is ignored. The second request is accepted at T+9.
- Reset mid-WAIT.
  - Stimulus: assert rst while in WAIT.
  - Required: no host_rsp_valid, all outputs at reset values. The next request after reset is accepted and completes normally.
